// File: rtl/poly_action_if.sv
// ---------------------------------------------------------------------------
// poly_action_if
// Bundles the strobes and results of the polyphonic action interpreter.
//   master : game/test side. Drives tick, key_trigger/key_data and
//            note_trigger/note_data; observes msg_*, scoring and enable.
//   slave  : interpreter side, the mirror image of master.
// Field layout:
//   key_data  [KEY_W] 1=press / 0=release, [KEY_W-1:0] key index
//   note_data [KEY_W+DUR_W-1:DUR_W] key, [DUR_W-1:0] duration in ticks
//   scoring   {bad, miss, late, early, good}, SCORE_W bits each, good in LSBs
// ---------------------------------------------------------------------------
interface poly_action_if #(
    parameter int CHANNELS = 4,
    parameter int KEY_W    = 6,
    parameter int DUR_W    = 12,
    parameter int SCORE_W  = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                     tick;
    logic                     key_trigger;
    logic [KEY_W:0]           key_data;
    logic                     note_trigger;
    logic [KEY_W+DUR_W-1:0]   note_data;
    logic                     msg_valid;
    logic [2:0]               msg;
    logic [CH_W-1:0]          msg_chan;
    logic                     msg_multi;
    logic [5*SCORE_W-1:0]     scoring;
    logic                     enable;

    modport master (
        output tick, key_trigger, key_data, note_trigger, note_data,
        input  msg_valid, msg, msg_chan, msg_multi, scoring, enable
    );

    modport slave (
        input  tick, key_trigger, key_data, note_trigger, note_data,
        output msg_valid, msg, msg_chan, msg_multi, scoring, enable
    );
endinterface

// File: rtl/poly_action_interpreter.sv
// ---------------------------------------------------------------------------
// poly_action_interpreter
// Tracks up to CHANNELS concurrent expected notes against the game tick and
// classifies key presses/releases. One registered message per cycle plus
// saturating per-category score counters.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low; clears all state
//   bus    poly_action_if.slave (strobes in, msg/scoring/enable out)
// ---------------------------------------------------------------------------
module poly_action_interpreter #(
    parameter int CHANNELS    = 4,
    parameter int KEY_W       = 6,
    parameter int DUR_W       = 12,
    parameter int SCORE_W     = 16,
    parameter int PRESS_WIN   = 10,
    parameter int RELEASE_WIN = 5
) (
    input  logic         clk,
    input  logic         reset,
    poly_action_if.slave bus
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EV_W = CH_W + 2;  // holds key + note + one tick event per channel
    // Timing comparisons are done one bit wider than DUR_W so dur+window cannot wrap.
    localparam logic [DUR_W:0] PRESS_LIM = (DUR_W+1)'(PRESS_WIN);
    localparam logic [DUR_W:0] REL_WIN   = (DUR_W+1)'(RELEASE_WIN);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HELD = 2'd2} ch_state_e;
    typedef enum logic [2:0] {
        MSG_NONE = 3'd0, MSG_MISS = 3'd1, MSG_BAD_PRESS = 3'd2, MSG_GOOD_PRESS = 3'd3,
        MSG_EARLY_RELEASE = 3'd4, MSG_GOOD_RELEASE = 3'd5, MSG_LATE_RELEASE = 3'd6,
        MSG_DROPPED = 3'd7
    } msg_e;

    ch_state_e          state_q [CHANNELS], state_d [CHANNELS];
    logic [KEY_W-1:0]   key_q   [CHANNELS], key_d   [CHANNELS];
    logic [DUR_W-1:0]   dur_q   [CHANNELS], dur_d   [CHANNELS];
    logic [DUR_W-1:0]   cnt_q   [CHANNELS], cnt_d   [CHANNELS];

    logic               msg_valid_q, msg_valid_d;
    msg_e               msg_q, msg_d;
    logic [CH_W-1:0]    msg_chan_q, msg_chan_d;
    logic               msg_multi_q, msg_multi_d;
    logic               enable_q, enable_d;
    logic [SCORE_W-1:0] good_q, good_d, early_q, early_d, late_q, late_d;
    logic [SCORE_W-1:0] miss_q, miss_d, bad_q, bad_d;

    logic               key_is_press;
    logic [KEY_W-1:0]   key_idx, note_key;
    logic [DUR_W-1:0]   note_dur;

    assign key_is_press = bus.key_data[KEY_W];
    assign key_idx      = bus.key_data[KEY_W-1:0];
    assign note_key     = bus.note_data[KEY_W+DUR_W-1:DUR_W];
    assign note_dur     = bus.note_data[DUR_W-1:0];

    // Working signals of the combinational evaluation.
    logic               key_ev, note_ev, tick_found, note_dup, free_found;
    msg_e               key_code, tick_code;
    logic [CH_W-1:0]    key_chan, tick_chan, free_chan;
    logic [CHANNELS-1:0] key_hit;
    logic               good_add, early_add, bad_add;
    logic [EV_W-1:0]    miss_add, late_add, ev_n;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [EV_W-1:0]    b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned -- otherwise a latch is inferred.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        dur_d      = dur_q;
        cnt_d      = cnt_q;
        key_ev     = 1'b0;
        key_code   = MSG_NONE;
        key_chan   = '0;
        key_hit    = '0;
        note_ev    = 1'b0;
        note_dup   = 1'b0;
        free_found = 1'b0;
        free_chan  = '0;
        tick_found = 1'b0;
        tick_code  = MSG_NONE;
        tick_chan  = '0;
        good_add   = 1'b0;
        early_add  = 1'b0;
        bad_add    = 1'b0;
        miss_add   = '0;
        late_add   = '0;

        // Key event, evaluated on pre-tick cnt. A press is bad unless a WAIT
        // channel of that key claims it; at most one channel holds a key.
        if (bus.key_trigger && key_is_press) begin
            key_ev   = 1'b1;
            key_code = MSG_BAD_PRESS;
            bad_add  = 1'b1;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.key_trigger && key_q[c] == key_idx) begin
                if (key_is_press && state_q[c] == ST_WAIT && {1'b0, cnt_q[c]} <= PRESS_LIM) begin
                    key_code   = MSG_GOOD_PRESS;
                    key_chan   = CH_W'(c);
                    key_hit[c] = 1'b1;
                    bad_add    = 1'b0;
                end else if (!key_is_press && state_q[c] == ST_HELD) begin
                    key_ev     = 1'b1;
                    key_chan   = CH_W'(c);
                    key_hit[c] = 1'b1;
                    if ({1'b0, cnt_q[c]} + REL_WIN < {1'b0, dur_q[c]}) begin
                        key_code  = MSG_EARLY_RELEASE;
                        early_add = 1'b1;
                    end else begin
                        key_code = MSG_GOOD_RELEASE;
                        good_add = 1'b1;
                    end
                end
            end
        end

        // Per-channel tick handling. A key event on the same channel wins
        // over its MISS/LATE tick; cnt still advances.
        for (int c = 0; c < CHANNELS; c++) begin
            if (key_hit[c]) begin
                state_d[c] = key_is_press ? ST_HELD : ST_IDLE;
            end
            if (bus.tick && state_q[c] != ST_IDLE) begin
                cnt_d[c] = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + DUR_W'(1);
                if (!key_hit[c]) begin
                    if (state_q[c] == ST_WAIT && {1'b0, cnt_q[c]} == PRESS_LIM) begin
                        state_d[c] = ST_IDLE;
                        miss_add   = miss_add + EV_W'(1);
                        if (!tick_found) begin
                            tick_found = 1'b1;
                            tick_code  = MSG_MISS;
                            tick_chan  = CH_W'(c);
                        end
                    end else if (state_q[c] == ST_HELD &&
                                 {1'b0, cnt_q[c]} == {1'b0, dur_q[c]} + REL_WIN) begin
                        state_d[c] = ST_IDLE;
                        late_add   = late_add + EV_W'(1);
                        if (!tick_found) begin
                            tick_found = 1'b1;
                            tick_code  = MSG_LATE_RELEASE;
                            tick_chan  = CH_W'(c);
                        end
                    end
                end
            end
        end

        // Note allocation looks at pre-cycle states: a channel freed this
        // cycle is still busy, and its key still counts as active.
        if (bus.note_trigger) begin
            for (int c = CHANNELS - 1; c >= 0; c--) begin
                if (state_q[c] != ST_IDLE && key_q[c] == note_key) note_dup = 1'b1;
                if (state_q[c] == ST_IDLE) begin
                    free_found = 1'b1;
                    free_chan  = CH_W'(c);
                end
            end
            if (note_dup || !free_found) begin
                note_ev = 1'b1;
            end else begin
                state_d[free_chan] = ST_WAIT;
                key_d[free_chan]   = note_key;
                dur_d[free_chan]   = note_dur;
                cnt_d[free_chan]   = '0;
            end
        end

        ev_n        = EV_W'(key_ev) + EV_W'(note_ev) + miss_add + late_add;
        msg_valid_d = (ev_n != '0);
        msg_multi_d = (ev_n > EV_W'(1));
        msg_d       = MSG_NONE;
        msg_chan_d  = '0;
        if (key_ev) begin
            msg_d      = key_code;
            msg_chan_d = key_chan;
        end else if (note_ev) begin
            msg_d = MSG_DROPPED;
        end else if (tick_found) begin
            msg_d      = tick_code;
            msg_chan_d = tick_chan;
        end

        enable_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (state_d[c] != ST_IDLE) enable_d = 1'b1;
        end

        good_d  = sat_add(good_q,  EV_W'(good_add));
        early_d = sat_add(early_q, EV_W'(early_add));
        late_d  = sat_add(late_q,  late_add);
        miss_d  = sat_add(miss_q,  miss_add);
        bad_d   = sat_add(bad_q,   EV_W'(bad_add));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the channel arrays are small register files and are reset
            // explicitly so a reset mid-note discards every slot.
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                key_q[c]   <= '0;
                dur_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
            msg_valid_q <= 1'b0;
            msg_q       <= MSG_NONE;
            msg_chan_q  <= '0;
            msg_multi_q <= 1'b0;
            enable_q    <= 1'b0;
            good_q      <= '0;
            early_q     <= '0;
            late_q      <= '0;
            miss_q      <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            dur_q       <= dur_d;
            cnt_q       <= cnt_d;
            msg_valid_q <= msg_valid_d;
            msg_q       <= msg_d;
            msg_chan_q  <= msg_chan_d;
            msg_multi_q <= msg_multi_d;
            enable_q    <= enable_d;
            good_q      <= good_d;
            early_q     <= early_d;
            late_q      <= late_d;
            miss_q      <= miss_d;
            bad_q       <= bad_d;
        end
    end

    assign bus.msg_valid = msg_valid_q;
    assign bus.msg       = msg_q;
    assign bus.msg_chan  = msg_chan_q;
    assign bus.msg_multi = msg_multi_q;
    assign bus.enable    = enable_q;
    assign bus.scoring   = {bad_q, miss_q, late_q, early_q, good_q};
endmodule

// File: tb/tb_poly_action_interpreter.sv
// ---------------------------------------------------------------------------
// tb_poly_action_interpreter
// Directed bench for poly_action_interpreter (default parameters). Inputs are
// driven 1 time unit after a rising edge; outputs are sampled at that point,
// i.e. the cycle after the strobe that caused them.
// ---------------------------------------------------------------------------
module tb_poly_action_interpreter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    poly_action_if bus ();

    poly_action_interpreter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_note(input logic [5:0] k, input logic [11:0] d);
        bus.note_trigger = 1'b1;
        bus.note_data    = {k, d};
        step();
        bus.note_trigger = 1'b0;
    endtask

    task automatic do_key(input logic press, input logic [5:0] k);
        bus.key_trigger = 1'b1;
        bus.key_data    = {press, k};
        step();
        bus.key_trigger = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    // {valid, code, chan, multi}
    task automatic check_msg(input string tag, input logic v, input logic [2:0] m,
                             input logic [1:0] ch, input logic mu);
        check(tag, 80'({bus.msg_valid, bus.msg, bus.msg_chan, bus.msg_multi}),
              80'({v, m, ch, mu}));
    endtask

    task automatic check_score(input string tag, input logic [15:0] g, input logic [15:0] e,
                               input logic [15:0] l, input logic [15:0] mi, input logic [15:0] b);
        check(tag, bus.scoring, {b, mi, l, e, g});
    endtask

    task automatic check_en(input string tag, input logic exp);
        check(tag, 80'(bus.enable), 80'(exp));
    endtask

    initial begin
        reset            = 1'b0;
        bus.tick         = 1'b0;
        bus.key_trigger  = 1'b0;
        bus.key_data     = '0;
        bus.note_trigger = 1'b0;
        bus.note_data    = '0;
        repeat (2) step();
        check_msg("reset_msg", 0, 0, 0, 0);
        check_score("reset_score", 0, 0, 0, 0, 0);
        check_en("reset_enable", 0);
        reset = 1'b1;
        step();

        // No press: MISS on the 11th tick (pre-tick cnt 10).
        do_note(6'd9, 12'd200);
        check_msg("alloc_quiet", 0, 0, 0, 0);
        check_en("alloc_enable", 1);
        do_ticks(10);
        check_msg("wait_cnt10_quiet", 0, 0, 0, 0);
        check_en("wait_enable", 1);
        do_ticks(1);
        check_msg("miss", 1, 3'd1, 0, 0);
        check_score("miss_score", 0, 0, 0, 1, 0);
        check_en("miss_enable_low", 0);
        step();
        check_msg("miss_single_pulse", 0, 0, 0, 0);

        // Bad press of key 10 while key 9 waits; key 9 still misses later.
        do_note(6'd9, 12'd200);
        do_ticks(7);
        do_key(1'b1, 6'd10);
        check_msg("bad_press", 1, 3'd2, 0, 0);
        check_score("bad_score", 0, 0, 0, 1, 1);
        check_en("bad_still_wait", 1);
        do_ticks(3);
        check_msg("bad_cnt10_quiet", 0, 0, 0, 0);
        do_ticks(1);
        check_msg("bad_then_miss", 1, 3'd1, 0, 0);
        check_score("bad_miss_score", 0, 0, 0, 2, 1);

        // Good press at cnt 3, good release at cnt 20 (dur 20).
        do_note(6'd9, 12'd20);
        do_ticks(3);
        do_key(1'b1, 6'd9);
        check_msg("good_press", 1, 3'd3, 0, 0);
        check_score("good_press_no_count", 0, 0, 0, 2, 1);
        do_ticks(17);
        do_key(1'b0, 6'd9);
        check_msg("good_release", 1, 3'd5, 0, 0);
        check_score("good_release_score", 1, 0, 0, 2, 1);
        check_en("good_release_idle", 0);

        // Early release: dur 40, release at cnt 18.
        do_note(6'd9, 12'd40);
        do_ticks(3);
        do_key(1'b1, 6'd9);
        do_ticks(15);
        do_key(1'b0, 6'd9);
        check_msg("early_release", 1, 3'd4, 0, 0);
        check_score("early_score", 1, 1, 0, 2, 1);

        // Release boundary with dur 20: cnt 14 is early, cnt 15 is good.
        do_note(6'd9, 12'd20);
        do_key(1'b1, 6'd9);
        do_ticks(14);
        do_key(1'b0, 6'd9);
        check_msg("release_cnt14_early", 1, 3'd4, 0, 0);
        do_note(6'd9, 12'd20);
        do_key(1'b1, 6'd9);
        do_ticks(15);
        do_key(1'b0, 6'd9);
        check_msg("release_cnt15_good", 1, 3'd5, 0, 0);
        check_score("release_boundary_score", 2, 2, 0, 2, 1);

        // Press exactly at cnt 10 is accepted; no release -> LATE on tick at cnt 25.
        do_note(6'd9, 12'd20);
        do_ticks(10);
        do_key(1'b1, 6'd9);
        check_msg("press_cnt10_good", 1, 3'd3, 0, 0);
        do_ticks(15);
        check_msg("held_cnt25_quiet", 0, 0, 0, 0);
        do_ticks(1);
        check_msg("late_release", 1, 3'd6, 0, 0);
        check_score("late_score", 2, 2, 1, 2, 1);
        check_en("late_idle", 0);

        // Release while WAIT is ignored; release of an unheld key is silent.
        do_note(6'd9, 12'd200);
        do_key(1'b0, 6'd9);
        check_msg("release_in_wait_quiet", 0, 0, 0, 0);
        check_en("release_in_wait_enable", 1);
        do_key(1'b1, 6'd9);
        check_msg("press_cnt0_good", 1, 3'd3, 0, 0);
        do_key(1'b0, 6'd11);
        check_msg("release_unmatched_quiet", 0, 0, 0, 0);
        do_key(1'b0, 6'd9);
        check_msg("release_cnt0_early", 1, 3'd4, 0, 0);
        check_score("wait_release_score", 2, 3, 1, 2, 1);

        // Polyphony: keys 1-4 fill all channels, key 5 dropped, four MISSes at once.
        do_note(6'd1, 12'd100);
        do_note(6'd2, 12'd100);
        do_note(6'd3, 12'd100);
        do_note(6'd4, 12'd100);
        check_msg("four_alloc_quiet", 0, 0, 0, 0);
        do_note(6'd5, 12'd100);
        check_msg("dropped_full", 1, 3'd7, 0, 0);
        check_en("dropped_enable", 1);
        do_ticks(10);
        check_msg("poly_cnt10_quiet", 0, 0, 0, 0);
        do_ticks(1);
        check_msg("quad_miss", 1, 3'd1, 0, 1);
        check_score("quad_miss_score", 2, 3, 1, 6, 1);
        check_en("quad_miss_idle", 0);

        // Channel mapping: second note lands in channel 1.
        do_note(6'd1, 12'd100);
        do_note(6'd2, 12'd100);
        do_key(1'b1, 6'd2);
        check_msg("press_chan1", 1, 3'd3, 2'd1, 0);

        // Press in the cycle of key 1's MISS tick wins.
        do_ticks(10);
        bus.tick        = 1'b1;
        bus.key_trigger = 1'b1;
        bus.key_data    = {1'b1, 6'd1};
        step();
        bus.tick        = 1'b0;
        bus.key_trigger = 1'b0;
        check_msg("collision_good_press", 1, 3'd3, 0, 0);
        check_score("collision_no_miss", 2, 3, 1, 6, 1);

        // Re-press while HELD is bad; note on an active key is dropped.
        do_key(1'b1, 6'd1);
        check_msg("repress_held_bad", 1, 3'd2, 0, 0);
        check_score("repress_score", 2, 3, 1, 6, 2);
        do_note(6'd2, 12'd50);
        check_msg("dropped_dup_key", 1, 3'd7, 0, 0);

        // Asynchronous reset while HELD clears outputs immediately.
        reset = 1'b0;
        #2;
        check_msg("async_reset_msg", 0, 0, 0, 0);
        check_score("async_reset_score", 0, 0, 0, 0, 0);
        check_en("async_reset_enable", 0);
        step();
        reset = 1'b1;
        do_key(1'b0, 6'd1);
        check_msg("post_reset_release_quiet", 0, 0, 0, 0);
        do_ticks(1);
        check_msg("post_reset_tick_quiet", 0, 0, 0, 0);
        check_score("post_reset_score", 0, 0, 0, 0, 0);
        check_en("post_reset_enable", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/poly_action_interpreter.md
# poly_action_interpreter

Polyphonic successor to the single-note action interpreter in the rhythm-game scoring path. Tracks up to CHANNELS concurrent expected notes and times each against the 10 ms game tick. Classifies every key press and release as good, early, late, missed or bad. Emits one registered message per cycle and keeps running per-category score counters for the display and scoring logic.

## Interface
- CHANNELS, 4: concurrent note slots.
- KEY_W, 6: key index width.
- DUR_W, 12: duration and tick-count width, in ticks.
- SCORE_W, 16: width of each score counter.
- PRESS_WIN, 10: ticks after note start within which a press is accepted.
- RELEASE_WIN, 5: ± ticks around the note duration within which a release is good.

- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low; clears all state.
- tick  in  1  one-cycle game-tick strobe.
- key_trigger  in  1  one-cycle key-event strobe.
- key_data  in  KEY_W+1  bit [KEY_W] 1=press, 0=release; [KEY_W-1:0] key index.
- note_trigger  in  1  one-cycle new-note strobe. The note starts now.
- note_data  in  KEY_W+DUR_W  [KEY_W+DUR_W-1:DUR_W] key, [DUR_W-1:0] duration in ticks.
- msg_valid  out  1  one-cycle pulse when msg is meaningful.
- msg  out  3  event code: 1 MISS, 2 BAD_PRESS, 3 GOOD_PRESS, 4 EARLY_RELEASE, 5 GOOD_RELEASE, 6 LATE_RELEASE, 7 DROPPED.
- msg_chan  out  clog2(CHANNELS)  channel the message refers to; 0 for BAD_PRESS.
- msg_multi  out  1  more than one event occurred in the reported cycle.
- scoring  out  5*SCORE_W  {bad, miss, late, early, good} counters, good in the LSBs.
- enable  out  1  high while any channel is non-IDLE.

## Operation
- Each channel has state IDLE/WAIT/HELD, plus key, dur and cnt registers.
- **note_trigger**
  - Allocates the lowest-index IDLE channel: key and dur loaded, cnt=0, state→WAIT.
  - No free channel, or the key is already active in any channel: DROPPED, and no state change.
  - At most one channel per key at any time.
- **tick**: every non-IDLE channel increments cnt, saturating at all-ones.
- **WAIT**
  - A press of the matching key with cnt ≤ PRESS_WIN → GOOD_PRESS, state→HELD, good counter not incremented.
  - A tick arriving with cnt==PRESS_WIN (pre-increment) → MISS, state→IDLE, miss+1.
  - A release of the matching key is ignored.
- **HELD**, on release of the matching key:
  - cnt+RELEASE_WIN < dur → EARLY_RELEASE, early+1.
  - Otherwise → GOOD_RELEASE, good+1.
  - Either way state→IDLE.
- **HELD**, on a tick arriving with cnt == dur+RELEASE_WIN (pre-increment) → LATE_RELEASE, late+1, state→IDLE.
- Comparisons use DUR_W+1 bits, so no overflow.
- A press whose key matches no WAIT channel → BAD_PRESS, bad+1. This includes a re-press while HELD.
- A release whose key matches no HELD channel produces no message.
- **Simultaneous events in one cycle**
  - Key and note evaluation use pre-tick cnt.
  - A press in the same cycle as that channel's MISS tick wins: GOOD_PRESS, no MISS.
  - A release in the same cycle as that channel's LATE tick wins: GOOD_RELEASE.
  - note_trigger allocation sees channel states before this cycle's frees.
- **Message arbitration**
  - Priority: key event > note event > tick events; among tick events, the lowest channel index wins.
  - msg_multi=1 when more than one event occurred in the cycle.
  - Counters count all events, each counter adding the number of its events in that cycle.
- Counters saturate at all-ones.

## Timing
- All outputs registered. msg_valid, msg, msg_chan and msg_multi appear in the cycle after the causing strobe.
- Counter updates are visible in the cycle after the event.
- State and enable change in the cycle after the strobe.
- Reset values: msg_valid=0, msg=0, msg_chan=0, msg_multi=0, scoring=0, enable=0, all channels IDLE. Reset applies immediately, asynchronously.
- Reset asserted mid-note discards the note silently, with no MISS message.
- Strobes are single-cycle. Back-to-back strobes on consecutive cycles are fully supported.

## Test plan
- **No press:** note key 9, dur 200, no key → MISS on tick 11 (cnt 10), miss=1, enable falls one cycle later.
- **Bad press:** note key 9, dur 200, press key 10 after 7 ticks → BAD_PRESS, msg_chan 0, bad=1; channel remains WAIT and later MISSes.
- **Good press, good release:** note key 9, dur 20, press at cnt 3, release at cnt 20 → GOOD_PRESS then GOOD_RELEASE, good=1.
- **Early release:** note key 9, dur 40, press at cnt 3, release at cnt 18 → EARLY_RELEASE, early=1. **Late release:** note key 9, dur 20, press at cnt 3, no release → LATE_RELEASE on the tick at cnt 25, late=1.
- **Polyphony:** notes on keys 1–4 fill channels 0–3; a fifth note on key 5 → DROPPED. No presses → four MISS events in the same cycle, msg_chan 0, msg_multi=1, miss=4.
- **Collision and reset:** a press of the matching key in the cycle of its MISS tick → GOOD_PRESS only. Reset asserted while HELD → all outputs 0 immediately, no message after release.
